// File: rtl/saxil_read_regbank.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | saxil_read_regbank : AXI4-Lite read-only register bank, 2-deep R FIFO     |
// | Revision 1.0                                                              |
// +--------------------------------------------------------------------------+
module saxil_read_regbank #(
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 32,
  parameter int NUM_REGS    = 16,
  parameter int SECURE_ONLY = 0
) (
  input  logic                       S_AXIL_ACLK,
  input  logic                       S_AXIL_ARESETn,
  input  logic                       S_AXIL_ARVALID,
  output logic                       S_AXIL_ARREADY,
  input  logic [ADDR_W-1:0]          S_AXIL_ARADDR,
  input  logic [2:0]                 S_AXIL_ARPROT,
  output logic                       S_AXIL_RVALID,
  input  logic                       S_AXIL_RREADY,
  output logic [DATA_W-1:0]          S_AXIL_RDATA,
  output logic [1:0]                 S_AXIL_RRESP,
  input  logic [NUM_REGS*DATA_W-1:0] reg_bank_in,
  output logic [NUM_REGS-1:0]        rd_strobe,
  output logic [15:0]                err_count
);

  localparam int          c_bytes = DATA_W / 8;
  localparam int          c_off_w = $clog2(c_bytes);
  localparam int          c_idx_w = $clog2(NUM_REGS);
  localparam logic [63:0] c_span  = 64'(NUM_REGS * c_bytes);
  localparam logic [1:0]  c_okay  = 2'b00;
  localparam logic [1:0]  c_slverr = 2'b10;

  logic [1:0]               count_q, count_d;
  logic                     rd_ptr_q, rd_ptr_d;
  logic                     wr_ptr_q, wr_ptr_d;
  logic [1:0][DATA_W-1:0]   data_q, data_d;
  logic [1:0][1:0]          resp_q, resp_d;
  logic                     arready_q, arready_d;
  logic [NUM_REGS-1:0]      strobe_q, strobe_d;
  logic [15:0]              err_q, err_d;

  logic                     w_push;
  logic                     w_pop;
  logic                     w_in_range;
  logic                     w_denied;
  logic                     w_ok;
  logic [c_idx_w-1:0]       w_idx;
  logic [DATA_W-1:0]        w_rd_word;
  logic                     w_unused_prot;

  // ARREADY is a flop so neither ARVALID nor RREADY reaches it combinationally.
  assign w_push     = S_AXIL_ARVALID && arready_q;
  assign w_pop      = (count_q != 2'd0) && S_AXIL_RREADY;
  assign w_in_range = 64'(S_AXIL_ARADDR) < c_span;
  assign w_denied   = (SECURE_ONLY != 0) && S_AXIL_ARPROT[1];
  assign w_ok       = w_in_range && !w_denied;
  assign w_idx      = S_AXIL_ARADDR[c_off_w +: c_idx_w];
  assign w_rd_word  = reg_bank_in[int'(w_idx) * DATA_W +: DATA_W];
  assign w_unused_prot = ^{S_AXIL_ARPROT[2], S_AXIL_ARPROT[0]};

  always_comb begin
    count_d  = count_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    data_d   = data_q;
    resp_d   = resp_q;
    strobe_d = '0;
    err_d    = err_q;

    unique case ({w_push, w_pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase

    if (w_pop) begin
      rd_ptr_d = ~rd_ptr_q;
    end

    if (w_push) begin
      wr_ptr_d         = ~wr_ptr_q;
      data_d[wr_ptr_q] = w_ok ? w_rd_word : '0;
      resp_d[wr_ptr_q] = w_ok ? c_okay : c_slverr;
      if (w_ok) begin
        strobe_d[w_idx] = 1'b1;
      end else if (err_q != 16'hFFFF) begin
        err_d = err_q + 16'd1;
      end
    end

    arready_d = (count_d != 2'd2);
  end

  always_ff @(posedge S_AXIL_ACLK or negedge S_AXIL_ARESETn) begin
    if (!S_AXIL_ARESETn) begin
      count_q   <= '0;
      rd_ptr_q  <= 1'b0;
      wr_ptr_q  <= 1'b0;
      data_q    <= '0;
      resp_q    <= '0;
      arready_q <= 1'b0;
      strobe_q  <= '0;
      err_q     <= '0;
    end else begin
      count_q   <= count_d;
      rd_ptr_q  <= rd_ptr_d;
      wr_ptr_q  <= wr_ptr_d;
      data_q    <= data_d;
      resp_q    <= resp_d;
      arready_q <= arready_d;
      strobe_q  <= strobe_d;
      err_q     <= err_d;
    end
  end

  assign S_AXIL_ARREADY = arready_q;
  assign S_AXIL_RVALID  = (count_q != 2'd0);
  assign S_AXIL_RDATA   = data_q[rd_ptr_q];
  assign S_AXIL_RRESP   = resp_q[rd_ptr_q];
  assign rd_strobe      = strobe_q;
  assign err_count      = err_q;

endmodule
`default_nettype wire

// File: tb/tb_saxil_read_regbank.sv
`default_nettype none
// Testbench for saxil_read_regbank: table vectors, corner sequences, random traffic.
module tb_saxil_read_regbank;

  localparam int DATA_W   = 32;
  localparam int ADDR_W   = 32;
  localparam int NUM_REGS = 16;

  logic                       clk = 1'b0;
  logic                       rst_n = 1'b0;
  logic                       arvalid, arready, rvalid, rready;
  logic [ADDR_W-1:0]          araddr;
  logic [2:0]                 arprot;
  logic [DATA_W-1:0]          rdata;
  logic [1:0]                 rresp;
  logic [NUM_REGS*DATA_W-1:0] bank;
  logic [NUM_REGS-1:0]        strobe;
  logic [15:0]                errc;
  logic [DATA_W-1:0]          regs [NUM_REGS];

  always #5 clk = ~clk;

  always_comb begin
    bank = '0;
    for (int i = 0; i < NUM_REGS; i++) bank[i*DATA_W +: DATA_W] = regs[i];
  end

  saxil_read_regbank #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_REGS(NUM_REGS), .SECURE_ONLY(1)
  ) dut (
    .S_AXIL_ACLK(clk), .S_AXIL_ARESETn(rst_n),
    .S_AXIL_ARVALID(arvalid), .S_AXIL_ARREADY(arready),
    .S_AXIL_ARADDR(araddr), .S_AXIL_ARPROT(arprot),
    .S_AXIL_RVALID(rvalid), .S_AXIL_RREADY(rready),
    .S_AXIL_RDATA(rdata), .S_AXIL_RRESP(rresp),
    .reg_bank_in(bank), .rd_strobe(strobe), .err_count(errc)
  );

  // Reference model: an ordered queue of pending responses.
  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [1:0]        resp;
  } rsp_t;

  rsp_t                q[$];
  logic [NUM_REGS-1:0] m_strobe = '0;
  int                  m_err = 0;
  bit                  armed = 1'b0;
  int                  checks = 0;
  int                  passed = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic void model_read(input logic [ADDR_W-1:0] a, input logic [2:0] p,
                                     output rsp_t r, output logic [NUM_REGS-1:0] s);
    s = '0;
    if (a >= NUM_REGS * 4 || p[1]) begin
      r.data = '0;
      r.resp = 2'b10;
    end else begin
      r.data = regs[a / 4];
      r.resp = 2'b00;
      s[a / 4] = 1'b1;
    end
  endfunction

  task automatic model_reset();
    q.delete();
    m_strobe = '0;
    m_err    = 0;
    armed    = 1'b0;
  endtask

  task automatic check_outputs(input string tag);
    chk({tag, ".arready"}, arready, armed && q.size() < 2);
    chk({tag, ".rvalid"}, rvalid, q.size() != 0);
    if (q.size() != 0) begin
      chk({tag, ".rdata"}, rdata, q[0].data);
      chk({tag, ".rresp"}, rresp, q[0].resp);
    end
    chk({tag, ".rd_strobe"}, strobe, m_strobe);
    chk({tag, ".err_count"}, errc, m_err);
  endtask

  // Called at a falling edge with inputs already driven; returns at the next falling edge.
  task automatic tick();
    rsp_t r;
    logic [NUM_REGS-1:0] s;
    bit acc, pp;
    acc = arvalid && armed && q.size() < 2;
    pp  = rready && q.size() != 0;
    model_read(araddr, arprot, r, s);
    @(posedge clk);
    if (!rst_n) begin
      model_reset();
    end else begin
      if (pp) void'(q.pop_front());
      if (acc) begin
        q.push_back(r);
        if (r.resp == 2'b10 && m_err != 65535) m_err++;
      end
      m_strobe = acc ? s : '0;
      armed    = 1'b1;
    end
    @(negedge clk);
  endtask

  typedef struct {
    logic [ADDR_W-1:0]   addr;
    logic [2:0]          prot;
    logic [DATA_W-1:0]   exp_data;
    logic [1:0]          exp_resp;
    logic [NUM_REGS-1:0] exp_strobe;
  } vec_t;

  vec_t               vecs [10];
  logic [DATA_W-1:0]  got [$];
  int                 acc_n, rsp_n;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected finish");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < NUM_REGS; i++) regs[i] = 32'h1000_0000 + i * 32'h0101;
    regs[2] = 32'hDEAD_BEEF;
    vecs[0] = '{32'h0000_0008, 3'b000, 32'hDEAD_BEEF, 2'b00, 16'h0004};
    vecs[1] = '{32'h0000_0040, 3'b000, 32'h0,         2'b10, 16'h0000};
    vecs[2] = '{32'h0000_0000, 3'b010, 32'h0,         2'b10, 16'h0000};
    vecs[3] = '{32'h0000_0000, 3'b000, 32'h1000_0000, 2'b00, 16'h0001};
    vecs[4] = '{32'h0000_003C, 3'b000, 32'h1000_0F0F, 2'b00, 16'h8000};
    vecs[5] = '{32'h0000_003F, 3'b101, 32'h1000_0F0F, 2'b00, 16'h8000};
    vecs[6] = '{32'h0000_0007, 3'b001, 32'h1000_0101, 2'b00, 16'h0002};
    vecs[7] = '{32'h8000_0008, 3'b000, 32'h0,         2'b10, 16'h0000};
    vecs[8] = '{32'h0000_0041, 3'b000, 32'h0,         2'b10, 16'h0000};
    vecs[9] = '{32'h0000_003B, 3'b011, 32'h0,         2'b10, 16'h0000};

    arvalid = 1'b0; rready = 1'b0; araddr = '0; arprot = '0;
    @(negedge clk);
    tick();
    check_outputs("reset");
    rst_n = 1'b1;
    check_outputs("post_reset");
    tick();

    // Table-driven single reads with RREADY held high.
    foreach (vecs[i]) begin
      arvalid = 1'b1; araddr = vecs[i].addr; arprot = vecs[i].prot; rready = 1'b1;
      check_outputs("vec_issue");
      tick();
      arvalid = 1'b0;
      chk($sformatf("vec%0d.rvalid", i), rvalid, 1'b1);
      chk($sformatf("vec%0d.rdata", i), rdata, vecs[i].exp_data);
      chk($sformatf("vec%0d.rresp", i), rresp, vecs[i].exp_resp);
      chk($sformatf("vec%0d.rd_strobe", i), strobe, vecs[i].exp_strobe);
      tick();
      check_outputs("vec_idle");
    end
    chk("table.err_count", errc, 16'd5);

    // Backpressure: two accepts fill the FIFO, the third waits.
    rready = 1'b0; arprot = 3'b000;
    arvalid = 1'b1; araddr = 32'h4; check_outputs("full_a"); tick();
    araddr = 32'h8; check_outputs("full_b"); tick();
    araddr = 32'hC; chk("full.arready_c", arready, 1'b0); check_outputs("full_c"); tick();
    chk("full.arready_d", arready, 1'b0);
    rready = 1'b1;
    got.delete();
    for (int c = 0; c < 10 && got.size() < 3; c++) begin
      if (rvalid && rready) got.push_back(rdata);
      check_outputs("drain");
      tick();
      if (!armed || arready == 1'b0) ; else if (c >= 1) arvalid = 1'b0;
    end
    arvalid = 1'b0;
    chk("order.count", got.size(), 3);
    for (int k = 0; k < 3; k++) chk($sformatf("order%0d", k), (got.size() > k) ? got[k] : 'x, regs[k+1]);
    for (int c = 0; c < 3; c++) begin check_outputs("order_idle"); tick(); end

    // Back-to-back throughput with RREADY high.
    acc_n = 0; rsp_n = 0; rready = 1'b1;
    for (int i = 0; i < 9; i++) begin
      arvalid = (i < 8); araddr = 32'(i * 4); arprot = 3'b000;
      if (arvalid && arready) acc_n++;
      if (rvalid && rready) rsp_n++;
      if (i >= 1) chk($sformatf("b2b%0d.rvalid", i), rvalid, 1'b1);
      check_outputs("b2b");
      tick();
    end
    arvalid = 1'b0;
    chk("b2b.accepts", acc_n, 8);
    chk("b2b.responses", rsp_n, 8);

    // Reset while the FIFO holds two entries.
    rready = 1'b0;
    arvalid = 1'b1; araddr = 32'h40; check_outputs("prerst_a"); tick();
    araddr = 32'h4; check_outputs("prerst_b"); tick();
    arvalid = 1'b0;
    chk("prerst.rvalid", rvalid, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    chk("midrst.rvalid", rvalid, 1'b0);
    chk("midrst.arready", arready, 1'b0);
    chk("midrst.err_count", errc, 16'd0);
    chk("midrst.rdata", rdata, 32'd0);
    @(negedge clk);
    tick();
    rst_n = 1'b1; rready = 1'b1;
    for (int c = 0; c < 3; c++) begin check_outputs("after_rst"); tick(); end

    // Randomised traffic against the queue model.
    for (int c = 0; c < 400; c++) begin
      arvalid = ($urandom_range(0, 3) != 0);
      rready  = ($urandom_range(0, 2) != 0);
      case ($urandom_range(0, 9))
        0:       araddr = $urandom;
        1:       araddr = $urandom_range(64, 80);
        default: araddr = $urandom_range(0, 63);
      endcase
      arprot = 3'($urandom_range(0, 7));
      regs[$urandom_range(0, NUM_REGS-1)] = $urandom;
      check_outputs("rand");
      tick();
    end
    arvalid = 1'b0; rready = 1'b1;
    for (int c = 0; c < 3; c++) begin check_outputs("final"); tick(); end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
`default_nettype wire
